// File: rtl/maxpool_pkg.sv
// Shared constants, word type and lane helpers for the AXI-Stream max-pool window.
// Default geometry lives here; the top-level parameters default to these values.
package maxpool_pkg;

    localparam int DEF_UNITS      = 8;
    localparam int DEF_GROUPS     = 2;
    localparam int DEF_COPIES     = 2;
    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_KW_MAX     = 4;

    function automatic int lanes_of(input int groups, input int units, input int copies);
        return groups * units * copies;
    endfunction

    function automatic int idx_w_of(input int kw_max);
        return (kw_max > 1) ? $clog2(kw_max) : 1;
    endfunction

    localparam int LANES = lanes_of(DEF_GROUPS, DEF_UNITS, DEF_COPIES);
    localparam int IDX_W = idx_w_of(DEF_KW_MAX);
    localparam int CNT_W = $clog2(DEF_KW_MAX + 1);

    typedef logic signed [DEF_WORD_WIDTH-1:0] word_t;

    localparam word_t WORD_MIN = {1'b1, {(DEF_WORD_WIDTH-1){1'b0}}};

    function automatic word_t lane_max(input word_t a, input word_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow slot.
// Input ready is a flop (empty overflow slot), so downstream ready never reaches it combinationally.
module axis_skid_buffer #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic          r_out_v;
    logic          r_skid_v;
    logic [DW-1:0] r_out_d;
    logic [DW-1:0] r_skid_d;
    logic          w_push;
    logic          w_out_free;

    assign w_push     = i_valid && !r_skid_v;
    assign w_out_free = !r_out_v || i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_out_d  <= '0;
            r_skid_d <= '0;
        end else if (w_out_free) begin
            if (r_skid_v) begin
                r_out_d  <= r_skid_d;
                r_out_v  <= 1'b1;
                r_skid_v <= 1'b0;
            end else begin
                r_out_v <= w_push;
                if (w_push) r_out_d <= i_data;
            end
        end else if (w_push) begin
            // Output is stalled: park the new beat in the overflow slot.
            r_skid_d <= i_data;
            r_skid_v <= 1'b1;
        end
    end

    assign o_ready = !r_skid_v;
    assign o_valid = r_out_v;
    assign o_data  = r_out_d;

endmodule

// File: rtl/axis_maxpool_window.sv
// Per-lane signed max over a run-time window of KW input beats, closed early by tlast.
// Optional MAXPOOL_ARGMAX_EN adds m_axis_tuser with the per-lane beat index of the max.
module axis_maxpool_window
    import maxpool_pkg::*;
#(
    parameter int UNITS      = DEF_UNITS,
    parameter int GROUPS     = DEF_GROUPS,
    parameter int COPIES     = DEF_COPIES,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int KW_MAX     = DEF_KW_MAX
) (
    input  logic                                                  aclk,
    input  logic                                                  areset,
    input  logic [$clog2(KW_MAX+1)-1:0]                           cfg_kw,
    input  logic                                                  s_axis_tvalid,
    output logic                                                  s_axis_tready,
    input  logic [lanes_of(GROUPS,UNITS,COPIES)*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [lanes_of(GROUPS,UNITS,COPIES)-1:0]              s_axis_tkeep,
    input  logic                                                  s_axis_tlast,
    output logic                                                  m_axis_tvalid,
    input  logic                                                  m_axis_tready,
    output logic [lanes_of(GROUPS,UNITS,COPIES)*WORD_WIDTH-1:0]   m_axis_tdata,
    output logic [lanes_of(GROUPS,UNITS,COPIES)-1:0]              m_axis_tkeep,
`ifdef MAXPOOL_ARGMAX_EN
    output logic [lanes_of(GROUPS,UNITS,COPIES)*idx_w_of(KW_MAX)-1:0] m_axis_tuser,
`endif
    output logic                                                  m_axis_tlast
);

    localparam int NL = lanes_of(GROUPS, UNITS, COPIES);
    localparam int CW = $clog2(KW_MAX + 1);
    localparam int DWIDTH = NL * WORD_WIDTH;
`ifdef MAXPOOL_ARGMAX_EN
    localparam int IW = idx_w_of(KW_MAX);
    localparam int SW = NL * IW + DWIDTH + NL + 1;
`else
    localparam int SW = DWIDTH + NL + 1;
`endif

    logic [CW-1:0]                r_cnt;
    logic [CW-1:0]                r_kw;
    logic signed [WORD_WIDTH-1:0] r_acc [NL];
    logic [NL-1:0]                r_keep;
    logic [CW-1:0]                w_kw_cfg;
    logic [CW-1:0]                w_kw_now;
    logic                         w_start;
    logic                         w_accept;
    logic                         w_close;
    logic                         w_in_ready;
    logic signed [WORD_WIDTH-1:0] w_din;
    logic signed [WORD_WIDTH-1:0] w_acc_nxt [NL];
    logic [NL-1:0]                w_keep_nxt;
    logic [DWIDTH-1:0]            w_data_out;
    logic [SW-1:0]                w_skid_in;
    logic [SW-1:0]                w_skid_out;
`ifdef MAXPOOL_ARGMAX_EN
    logic [IW-1:0]                r_idx [NL];
    logic [IW-1:0]                w_idx_nxt [NL];
    logic [NL*IW-1:0]             w_user_out;
`endif

    always_comb begin
        w_kw_cfg = cfg_kw;
        if (cfg_kw == '0)
            w_kw_cfg = CW'(1);
        else if (cfg_kw > CW'(KW_MAX))
            w_kw_cfg = CW'(KW_MAX);
    end

    assign w_start  = (r_cnt == '0);
    assign w_kw_now = w_start ? w_kw_cfg : r_kw;
    assign w_accept = s_axis_tvalid && w_in_ready;
    assign w_close  = w_accept && (((r_cnt + CW'(1)) == w_kw_now) || s_axis_tlast);

    always_comb begin
        w_din      = '0;
        w_keep_nxt = '0;
        w_data_out = '0;
`ifdef MAXPOOL_ARGMAX_EN
        w_user_out = '0;
`endif
        for (int i = 0; i < NL; i++) begin
            w_din = s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH];
            w_acc_nxt[i] = '0;
`ifdef MAXPOOL_ARGMAX_EN
            w_idx_nxt[i] = '0;
`endif
            if (w_start) begin
                w_acc_nxt[i]  = s_axis_tkeep[i] ? w_din : WORD_MIN;
                w_keep_nxt[i] = s_axis_tkeep[i];
            end else begin
                w_acc_nxt[i]  = s_axis_tkeep[i] ? lane_max(r_acc[i], w_din) : r_acc[i];
                w_keep_nxt[i] = r_keep[i] | s_axis_tkeep[i];
`ifdef MAXPOOL_ARGMAX_EN
                // Strict greater-than keeps the earliest index on ties.
                w_idx_nxt[i] = r_idx[i];
                if (s_axis_tkeep[i] && (!r_keep[i] || w_din > r_acc[i]))
                    w_idx_nxt[i] = IW'(r_cnt);
`endif
            end
            w_data_out[i*WORD_WIDTH +: WORD_WIDTH] = w_keep_nxt[i] ? w_acc_nxt[i] : '0;
`ifdef MAXPOOL_ARGMAX_EN
            w_user_out[i*IW +: IW] = w_keep_nxt[i] ? w_idx_nxt[i] : '0;
`endif
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cnt  <= '0;
            r_kw   <= CW'(1);
            r_acc  <= '{default: '0};
            r_keep <= '0;
`ifdef MAXPOOL_ARGMAX_EN
            r_idx  <= '{default: '0};
`endif
        end else if (w_accept) begin
            r_acc  <= w_acc_nxt;
            r_keep <= w_keep_nxt;
`ifdef MAXPOOL_ARGMAX_EN
            r_idx  <= w_idx_nxt;
`endif
            if (w_start) r_kw <= w_kw_cfg;
            r_cnt <= w_close ? '0 : r_cnt + CW'(1);
        end
    end

`ifdef MAXPOOL_ARGMAX_EN
    assign w_skid_in = {w_user_out, w_data_out, w_keep_nxt, s_axis_tlast};
    assign m_axis_tuser = w_skid_out[SW-1 -: NL*IW];
`else
    assign w_skid_in = {w_data_out, w_keep_nxt, s_axis_tlast};
`endif

    axis_skid_buffer #(.DW(SW)) u_skid (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_valid (w_close),
        .o_ready (w_in_ready),
        .i_data  (w_skid_in),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready),
        .o_data  (w_skid_out)
    );

    assign s_axis_tready = w_in_ready;
    assign m_axis_tdata  = w_skid_out[NL+1 +: DWIDTH];
    assign m_axis_tkeep  = w_skid_out[1 +: NL];
    assign m_axis_tlast  = w_skid_out[0];

endmodule

// File: tb/tb_axis_maxpool_window.sv
// Directed bench for axis_maxpool_window with a window-list reference model.
// Build with MAXPOOL_ARGMAX_EN to also check m_axis_tuser.
module tb_axis_maxpool_window;

    localparam int NL = 32;
    localparam int WW = 8;
    localparam int KWM = 4;
    localparam int IW = 2;

    logic              aclk = 1'b0;
    logic              areset;
    logic [2:0]        cfg_kw;
    logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [NL*WW-1:0]  s_axis_tdata;
    logic [NL-1:0]     s_axis_tkeep;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [NL*WW-1:0]  m_axis_tdata;
    logic [NL-1:0]     m_axis_tkeep;
    logic [NL*IW-1:0]  m_user;

    axis_maxpool_window dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_kw        (cfg_kw),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
`ifdef MAXPOOL_ARGMAX_EN
        .m_axis_tuser  (m_user),
`endif
        .m_axis_tlast  (m_axis_tlast)
    );

`ifndef MAXPOOL_ARGMAX_EN
    assign m_user = '0;
`endif

    always #5 aclk = ~aclk;

    typedef struct {
        logic [NL*WW-1:0] d;
        logic [NL-1:0]    k;
        logic             l;
        logic [NL*IW-1:0] u;
    } beat_t;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t log_q[$];

    int             m_max [NL];
    int             m_idx [NL];
    logic [NL-1:0]  m_keep;
    int             m_n = 0;
    int             m_kw = 1;
    logic           p_stall = 1'b0;
    beat_t          p_beat;

    function automatic int lane_of(input logic [NL*WW-1:0] d, input int i);
        return int'($signed(d[i*WW +: WW]));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: collect accepted beats into a window, emit its reduction when it closes.
    always @(negedge aclk) begin
        beat_t cur;
        cur.d = m_axis_tdata; cur.k = m_axis_tkeep; cur.l = m_axis_tlast; cur.u = m_user;
        if (areset) begin
            m_n = 0;
            exp_q.delete();
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                n_cmp++;
                if (!m_axis_tvalid || cur.d !== p_beat.d || cur.k !== p_beat.k || cur.l !== p_beat.l) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%0b data changed while stalled", m_axis_tvalid);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out: got output beat, expected none");
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (cur.d !== e.d) begin n_err++; $display("FAIL out_data: got %h expected %h", cur.d, e.d); end
                    n_cmp++;
                    if (cur.k !== e.k) begin n_err++; $display("FAIL out_keep: got %h expected %h", cur.k, e.k); end
                    n_cmp++;
                    if (cur.l !== e.l) begin n_err++; $display("FAIL out_last: got %0b expected %0b", cur.l, e.l); end
`ifdef MAXPOOL_ARGMAX_EN
                    n_cmp++;
                    if (cur.u !== e.u) begin n_err++; $display("FAIL out_user: got %h expected %h", cur.u, e.u); end
`endif
                end
                log_q.push_back(cur);
            end
            p_stall = m_axis_tvalid && !m_axis_tready;
            p_beat = cur;
            if (s_axis_tvalid && s_axis_tready) begin
                if (m_n == 0) begin
                    m_kw = (cfg_kw == 0) ? 1 : ((cfg_kw > KWM) ? KWM : int'(cfg_kw));
                    m_keep = '0;
                    for (int i = 0; i < NL; i++) begin m_max[i] = 0; m_idx[i] = 0; end
                end
                for (int i = 0; i < NL; i++) begin
                    if (s_axis_tkeep[i] && (!m_keep[i] || lane_of(s_axis_tdata, i) > m_max[i])) begin
                        m_max[i] = lane_of(s_axis_tdata, i);
                        m_idx[i] = m_n;
                    end
                    if (s_axis_tkeep[i]) m_keep[i] = 1'b1;
                end
                m_n++;
                if (m_n == m_kw || s_axis_tlast) begin
                    beat_t e;
                    e.k = m_keep; e.l = s_axis_tlast; e.d = '0; e.u = '0;
                    for (int i = 0; i < NL; i++) begin
                        if (m_keep[i]) begin
                            e.d[i*WW +: WW] = WW'(m_max[i]);
                            e.u[i*IW +: IW] = IW'(m_idx[i]);
                        end
                    end
                    exp_q.push_back(e);
                    m_n = 0;
                end
            end
        end
    end

    function automatic logic [NL*WW-1:0] mk(input int l0, input int l1);
        logic [NL*WW-1:0] d;
        d = '0;
        for (int i = 2; i < NL; i++) d[i*WW +: WW] = WW'($urandom);
        d[0 +: WW]  = WW'(l0);
        d[WW +: WW] = WW'(l1);
        return d;
    endfunction

    task automatic send(input logic [NL*WW-1:0] d, input logic [NL-1:0] k, input logic l);
        bit ok;
        ok = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
        for (int t = 0; t < 100; t++) begin
            @(negedge aclk);
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got no s_axis_tready, expected acceptance");
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit saw_low;
        areset = 1'b1; cfg_kw = 3'd1; m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge aclk);
        #3 areset = 1'b0;
        idle(1);
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_tdata",  int'(m_axis_tdata == '0), 1);
        chk("rst_tkeep",  int'(m_axis_tkeep == '0), 1);
        chk("rst_tlast",  int'(m_axis_tlast), 0);
        chk("rst_tready", int'(s_axis_tready), 1);

        // Basic kw=2 window.
        base = log_q.size();
        cfg_kw = 3'd2;
        send(mk(5, -7), '1, 1'b0);
        chk("basic_no_early", int'(m_axis_tvalid), 0);
        send(mk(-3, -2), '1, 1'b0);
        chk("basic_latency", int'(m_axis_tvalid), 1);
        idle(3);
        chk("basic_count", log_q.size() - base, 1);
        chk("basic_lane0", lane_of(log_q[base].d, 0), 5);
        chk("basic_lane1", lane_of(log_q[base].d, 1), -2);
        chk("basic_keep",  int'(log_q[base].k[1:0]), 3);
        chk("basic_last",  int'(log_q[base].l), 0);

        // tlast closes a kw=3 window after 2 beats; next beat re-samples cfg_kw.
        base = log_q.size();
        cfg_kw = 3'd3;
        send(mk(1, 0), '1, 1'b0);
        send(mk(9, 0), '1, 1'b1);
        cfg_kw = 3'd1;
        send(mk(4, 0), '1, 1'b0);
        idle(3);
        chk("partial_count", log_q.size() - base, 2);
        chk("partial_lane0", lane_of(log_q[base].d, 0), 9);
        chk("partial_last",  int'(log_q[base].l), 1);
        chk("resample_lane0", lane_of(log_q[base+1].d, 0), 4);

        // Keep masking.
        base = log_q.size();
        cfg_kw = 3'd2;
        send(mk(100, 11), {{(NL-2){1'b1}}, 2'b00}, 1'b0);
        send(mk(-5, 50),  {{(NL-2){1'b1}}, 2'b01}, 1'b0);
        idle(3);
        chk("keep_lane0", lane_of(log_q[base].d, 0), -5);
        chk("keep_k0",    int'(log_q[base].k[0]), 1);
        chk("keep_lane1", lane_of(log_q[base].d, 1), 0);
        chk("keep_k1",    int'(log_q[base].k[1]), 0);

        // Backpressure with kw=1.
        base = log_q.size();
        cfg_kw = 3'd1;
        saw_low = 1'b0;
        fork
            for (int k = 1; k <= 6; k++) send(mk(k, 0), '1, 1'b0);
            begin
                @(posedge aclk); #1 m_axis_tready = 1'b0;
                repeat (4) @(posedge aclk);
                #1 m_axis_tready = 1'b1;
            end
            for (int t = 0; t < 12; t++) begin
                @(negedge aclk);
                if (!s_axis_tready) saw_low = 1'b1;
            end
        join
        idle(6);
        chk("bp_ready_low", int'(saw_low), 1);
        chk("bp_count", log_q.size() - base, 6);
        for (int k = 0; k < 6; k++)
            if (base + k < log_q.size()) chk("bp_order", lane_of(log_q[base+k].d, 0), k + 1);

        // cfg_kw=0 acts as 1, cfg_kw=7 clamps to 4.
        base = log_q.size();
        cfg_kw = 3'd0;
        send(mk(1, 0), '1, 1'b0);
        send(mk(2, 0), '1, 1'b0);
        idle(3);
        chk("kw0_count", log_q.size() - base, 2);
        base = log_q.size();
        cfg_kw = 3'd7;
        for (int k = 1; k <= 4; k++) send(mk(k, 0), '1, 1'b0);
        for (int k = 1; k <= 4; k++) send(mk(-k, 0), '1, 1'b0);
        idle(3);
        chk("kw7_count", log_q.size() - base, 2);
        if (log_q.size() - base == 2) begin
            chk("kw7_max0", lane_of(log_q[base].d, 0), 4);
            chk("kw7_max1", lane_of(log_q[base+1].d, 0), -1);
        end

        // Reset mid-window discards the partial window.
        cfg_kw = 3'd4;
        send(mk(120, 0), '1, 1'b0);
        send(mk(121, 0), '1, 1'b0);
        areset = 1'b1;
        #2;
        chk("arst_tvalid", int'(m_axis_tvalid), 0);
        chk("arst_tdata",  int'(m_axis_tdata == '0), 1);
        chk("arst_tkeep",  int'(m_axis_tkeep == '0), 1);
        chk("arst_tlast",  int'(m_axis_tlast), 0);
        repeat (2) @(posedge aclk);
        #3 areset = 1'b0;
        idle(1);
        base = log_q.size();
        send(mk(10, 0), '1, 1'b0);
        send(mk(20, 0), '1, 1'b0);
        send(mk(40, 0), '1, 1'b0);
        send(mk(30, 0), '1, 1'b0);
        idle(3);
        chk("post_rst_count", log_q.size() - base, 1);
        if (log_q.size() - base == 1) chk("post_rst_lane0", lane_of(log_q[base].d, 0), 40);

`ifdef MAXPOOL_ARGMAX_EN
        base = log_q.size();
        cfg_kw = 3'd4;
        send(mk(3, 0), '1, 1'b0);
        send(mk(8, 0), '1, 1'b0);
        send(mk(8, 0), '1, 1'b0);
        send(mk(2, 0), '1, 1'b0);
        idle(3);
        chk("argmax_count", log_q.size() - base, 1);
        if (log_q.size() - base == 1) begin
            chk("argmax_lane0", lane_of(log_q[base].d, 0), 8);
            chk("argmax_idx0",  int'(log_q[base].u[IW-1:0]), 1);
        end
`endif

        chk("exp_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
